sha3_digest_serializer: RTL



---
 rtl/sha3_digest_serializer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sha3_digest_serializer.sv
// Captures the final Keccak state on a one-cycle strobe and streams the leading
// digest lanes out as OUT_WIDTH-bit words over a valid/ready handshake.
module sha3_digest_serializer #(
  parameter int DIGEST_LANES = 4,
  parameter int OUT_WIDTH    = 32,
  parameter bit BYTESWAP     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0][63:0]     isa,
  input  logic [4:0][63:0]     isb,
  input  logic [4:0][63:0]     isc,
  input  logic [4:0][63:0]     isd,
  input  logic [4:0][63:0]     ise,
  input  logic                 sample,
  output logic                 oready,
  output logic [OUT_WIDTH-1:0] odata,
  output logic                 ovalid,
  input  logic                 iready,
  output logic                 olast,
  output logic                 odropped
);

  localparam int WORDS = DIGEST_LANES * 64 / OUT_WIDTH;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  genvar gi;

  generate
    if (!(OUT_WIDTH == 32 || OUT_WIDTH == 64)) begin : g_bad_width
      $error("sha3_digest_serializer: OUT_WIDTH must be 32 or 64");
    end
    if (DIGEST_LANES < 1 || DIGEST_LANES > 25) begin : g_bad_lanes
      $error("sha3_digest_serializer: DIGEST_LANES must be 1..25");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t                             state_reg;
  logic [CW-1:0]                      cnt_reg;
  logic [CW-1:0]                      cnt_inc;
  logic [DIGEST_LANES-1:0][63:0]      cap;
  logic [DIGEST_LANES-1:0][63:0]      capture_reg;
  logic [WORDS-1:0][OUT_WIDTH-1:0]    cap_words;
  logic [WORDS-1:0][OUT_WIDTH-1:0]    words;
  logic [OUT_WIDTH-1:0]               next_raw;
  logic [OUT_WIDTH-1:0]               next_word;
  logic [OUT_WIDTH-1:0]               odata_reg;
  logic                               ovalid_reg;
  logic                               olast_reg;
  logic                               oready_reg;
  logic                               odropped_reg;
  logic                               unused_rows;

  // Lane L lives in row L/5, column L%5.
  generate
    for (gi = 0; gi < DIGEST_LANES; gi++) begin : g_lane
      localparam int ROW = gi / 5;
      localparam int COL = gi % 5;
      if (ROW == 0) begin : g_a
        assign cap[gi] = isa[COL];
      end else if (ROW == 1) begin : g_b
        assign cap[gi] = isb[COL];
      end else if (ROW == 2) begin : g_c
        assign cap[gi] = isc[COL];
      end else if (ROW == 3) begin : g_d
        assign cap[gi] = isd[COL];
      end else begin : g_e
        assign cap[gi] = ise[COL];
      end
    end
  endgenerate

  assign unused_rows = ^{isa, isb, isc, isd, ise};

  // Packed lane order puts the low half of lane k ahead of its high half.
  assign cap_words = cap;
  assign words     = capture_reg;
  assign cnt_inc   = cnt_reg + 1'b1;

  always_comb begin
    next_raw = words[cnt_inc];
    if (state_reg == IDLE) begin
      next_raw = cap_words[0];
    end
  end

  generate
    for (gi = 0; gi < OUT_WIDTH / 8; gi++) begin : g_byte
      if (BYTESWAP) begin : g_swap
        assign next_word[gi*8 +: 8] = next_raw[(OUT_WIDTH/8 - 1 - gi)*8 +: 8];
      end else begin : g_pass
        assign next_word[gi*8 +: 8] = next_raw[gi*8 +: 8];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (state_reg == IDLE && sample) begin
      capture_reg <= cap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      odata_reg    <= '0;
      ovalid_reg   <= 1'b0;
      olast_reg    <= 1'b0;
      oready_reg   <= 1'b1;
      odropped_reg <= 1'b0;
    end else begin
      odropped_reg <= (state_reg == SEND) && sample;
      case (state_reg)
        IDLE: begin
          if (sample) begin
            state_reg  <= SEND;
            cnt_reg    <= '0;
            odata_reg  <= next_word;
            ovalid_reg <= 1'b1;
            olast_reg  <= (LAST == '0);
            oready_reg <= 1'b0;
          end
        end
        SEND: begin
          if (iready) begin
            if (cnt_reg == LAST) begin
              state_reg  <= IDLE;
              odata_reg  <= '0;
              ovalid_reg <= 1'b0;
              olast_reg  <= 1'b0;
              oready_reg <= 1'b1;
            end else begin
              cnt_reg   <= cnt_inc;
              odata_reg <= next_word;
              olast_reg <= (cnt_inc == LAST);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign oready   = oready_reg;
  assign odata    = odata_reg;
  assign ovalid   = ovalid_reg;
  assign olast    = olast_reg;
  assign odropped = odropped_reg;

endmodule
